revelar_cascada: RTL and testbench
==================================

Name: revelar_cascada

Overview:
- Flood-fill reveal controller for the 8x8 minesweeper board register.
- On start it reveals the selected cell. If that cell has zero adjacent bombs, it walks outward breadth-first and reveals connected cells until every zero-count region is bounded.
- It sits between the game FSM (which raises start after a non-bomb selection) and the board register. It sequences one board read and at most one board write per cycle.

Parameters:
- N, 8, board side length (cells per row and per column).
- IDX_W, 3, coordinate width; must equal clog2(N).
- QDEPTH, 64, coordinate queue depth; must equal N*N.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to begin a cascade
- i_inicio  in  IDX_W  row of the selected cell
- j_inicio  in  IDX_W  column of the selected cell
- rd_i  out  IDX_W  board read row address
- rd_j  out  IDX_W  board read column address
- rd_data  in  7  board cell at (rd_i, rd_j); combinational, same-cycle read
- wr_en  out  1  set revealed bit of cell (wr_i, wr_j) at next clk edge
- wr_i  out  IDX_W  write row
- wr_j  out  IDX_W  write column
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse when the cascade completes
- reveal_cnt  out  7  cells revealed by the last cascade (0..64)

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Cell encoding (shared package):
  - bits [3:0] = adjacent bomb count, 0..8
  - bit 4 = bomb
  - bit 5 = revealed
  - bit 6 = flag
- Reset values: all outputs 0; FSM in IDLE; queue empty; visited bitmap all 0.
- States:
  - IDLE: start=1 -> clear visited, push (i_inicio, j_inicio), mark it visited, clear reveal_cnt -> POP. start is ignored in all other states.
  - POP: queue empty -> DONE. Otherwise pop head, drive rd_i/rd_j with it -> CHECK.
  - CHECK (same-cycle decode of rd_data):
    - Flag, bomb or revealed set -> no write, go to POP.
    - Else: wr_en=1 for exactly this cycle, reveal_cnt+1. Count==0 -> EXPAND with neighbour index k=0; else -> POP.
  - EXPAND: examine one neighbour per cycle, order N, E, S, W, then NE, SE, SW, NW.
    - Out-of-range coordinates (row or column <0 or >N-1) are skipped; no wrap-around.
    - In-range and not visited -> push and mark visited.
    - After the last neighbour -> POP.
  - DONE: done=1 for one cycle, busy=0 -> IDLE.
- Neighbour arithmetic uses IDX_W+1 signed bits so range checks are exact at 0 and N-1.
- No duplicates: the visited bitmap is set at push time, not pop time. A cell is therefore enqueued at most once, the queue never overflows, and there is no full stall.
- Simultaneous push and pop cannot occur: pops happen only in POP, pushes only in IDLE and EXPAND.
- Flagged cells are never revealed and never expanded. Board cells are unchanged except for bit 5.
- Latency:
  - Minimum start -> done is 4 cycles (start cell nonzero count).
  - Each zero-count cell adds 2 + neighbour-count cycles.
- reveal_cnt holds after DONE until the next accepted start.
- rst mid-cascade: rst has priority in the cycle it is sampled. No write at that edge, FSM returns to IDLE, queue and bitmap cleared, busy=0, done=0. Cells already written stay revealed.

Optional Feature:
- Macro: FLOOD_DIAG_EN.
- Defined: EXPAND visits all 8 neighbours, matching standard minesweeper, 8 EXPAND cycles per zero cell.
- Undefined: EXPAND visits only N, E, S, W, 4 cycles per zero cell. Diagonal cells are revealed only when reached orthogonally.

Decomposition:
- Package buscaminas_pkg:
  - N and IDX_W constants.
  - Cell bit-position constants: CNT_LSB=0, CNT_MSB=3, BOMB_BIT=4, REVEAL_BIT=5, FLAG_BIT=6.
  - State enum typedef: IDLE, POP, CHECK, EXPAND, DONE.
  - Packed coordinate struct typedef {i, j}.
  - Neighbour offset table.
- Sub-module cola_coord: synchronous FIFO of coordinate structs, depth QDEPTH, with push, pop, empty and registered head. Instantiated once.

Test Plan:
- Start on (3,3), count=2, no flag -> one wr_en at (3,3), reveal_cnt=1, done 4 cycles after start.
- Start on (0,0) of a board with a single bomb at (7,7):
  - FLOOD_DIAG_EN defined -> 63 distinct writes, (7,7) never written, reveal_cnt=63.
  - Undefined -> reveal_cnt matches the orthogonal-only fill computed by the reference model.
- Zero region containing a flagged cell at (2,2) -> (2,2) never written, bit 6 preserved, cells beyond reached only through (2,2) stay hidden.
- Start on (0,7) corner, zero count -> no out-of-range addresses on rd_i/rd_j; EXPAND pushes only in-range neighbours.
- Start on an already-revealed cell -> zero writes, reveal_cnt=0, done pulses. A second start pulsed while busy -> ignored, single done.
- rst asserted on the 10th busy cycle -> next cycle busy=0, wr_en=0, done=0; a new start then runs a clean cascade with reveal_cnt restarting from 0.

Source files
------------

// File: rtl/buscaminas_pkg.sv
// ---------------------------------------------------------------------------
// buscaminas_pkg
//   Shared definitions for the 8x8 minesweeper board logic.
//   - Board geometry: N (side), IDX_W (coordinate width), QDEPTH (N*N).
//   - Cell bit positions inside the 7-bit board word:
//       [3:0] adjacent bomb count, [4] bomb, [5] revealed, [6] flag.
//   - state_t : flood-fill controller states.
//   - coord_t : packed {i (row), j (column)} coordinate.
//   - off_di / off_dj : neighbour offset table, index k = 0..7 in the
//     order N, E, S, W, NE, SE, SW, NW.
//   - cell_idx : flat bitmap index of a coordinate.
// ---------------------------------------------------------------------------
package buscaminas_pkg;

  localparam int N      = 8;
  localparam int IDX_W  = 3;
  localparam int QDEPTH = N * N;

  localparam int CELL_W     = 7;
  localparam int CNT_LSB    = 0;
  localparam int CNT_MSB    = 3;
  localparam int BOMB_BIT   = 4;
  localparam int REVEAL_BIT = 5;
  localparam int FLAG_BIT   = 6;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    POP    = 3'd1,
    CHECK  = 3'd2,
    EXPAND = 3'd3,
    DONE   = 3'd4
  } state_t;

  typedef struct packed {
    logic [IDX_W-1:0] i;
    logic [IDX_W-1:0] j;
  } coord_t;

  // Signed offsets are IDX_W+1 bits wide so that a step off either edge of
  // the board shows up in the sign bit instead of wrapping to a valid index.
  localparam logic signed [IDX_W:0] D_NEG  = '1;
  localparam logic signed [IDX_W:0] D_ZERO = '0;
  localparam logic signed [IDX_W:0] D_POS  = {{IDX_W{1'b0}}, 1'b1};

  // Row offset: N, NE, NW go up; S, SE, SW go down; E, W stay.
  function automatic logic signed [IDX_W:0] off_di(input logic [2:0] k);
    case (k)
      3'd0, 3'd4, 3'd7: off_di = D_NEG;
      3'd2, 3'd5, 3'd6: off_di = D_POS;
      default:          off_di = D_ZERO;
    endcase
  endfunction

  // Column offset: E, NE, SE go right; W, SW, NW go left; N, S stay.
  function automatic logic signed [IDX_W:0] off_dj(input logic [2:0] k);
    case (k)
      3'd1, 3'd4, 3'd5: off_dj = D_POS;
      3'd3, 3'd6, 3'd7: off_dj = D_NEG;
      default:          off_dj = D_ZERO;
    endcase
  endfunction

  // N is a power of two, so row-major index i*N + j is just {i, j}.
  function automatic logic [2*IDX_W-1:0] cell_idx(input coord_t c);
    cell_idx = {c.i, c.j};
  endfunction

endpackage

// File: rtl/revelar_cascada_cola_coord.sv
// ---------------------------------------------------------------------------
// cola_coord
//   Synchronous FIFO of board coordinates used as the breadth-first queue.
//   Storage is an inferred RAM array; the head is a registered read that is
//   loaded on pop, so it is valid from the cycle after the pop and holds
//   until the next pop.
// Ports:
//   clk, rst   clock, synchronous active-high reset (empties the queue)
//   push       write push_data at the tail this cycle
//   push_data  coordinate to enqueue
//   pop        remove the front entry and load it into head (ignored if empty)
//   empty      queue holds no entries
//   head       last popped coordinate
// The controller never pushes more than DEPTH entries per run, so there is
// no full flag.
// ---------------------------------------------------------------------------
module cola_coord
  import buscaminas_pkg::*;
#(
  parameter int DEPTH = QDEPTH
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  coord_t push_data,
  input  logic   pop,
  output logic   empty,
  output coord_t head
);

  localparam int AW = $clog2(DEPTH);

  coord_t      mem [DEPTH];
  coord_t      head_q;
  // One extra pointer bit distinguishes full from empty.
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        do_pop;

  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign do_pop = pop && !empty;
  assign head   = head_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // RAM write port; contents need no reset because the pointers define
  // which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q[AW-1:0]] <= push_data;
    end
  end

  // Registered RAM read port.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
    end else if (do_pop) begin
      head_q <= mem[rd_ptr_q[AW-1:0]];
    end
  end

endmodule

// File: rtl/revelar_cascada.sv
// ---------------------------------------------------------------------------
// revelar_cascada
//   Flood-fill reveal controller for the 8x8 minesweeper board register.
//   On start it reveals the selected cell; a zero-count cell is expanded
//   breadth-first through a coordinate queue until every zero region is
//   bounded. One board read and at most one board write per cycle.
//
// Build option:
//   FLOOD_DIAG_EN  defined   -> expand all 8 neighbours (N,E,S,W,NE,SE,SW,NW)
//                  undefined -> expand only N,E,S,W
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   start              one-cycle request, accepted only in IDLE
//   i_inicio/j_inicio  selected cell row/column
//   rd_i/rd_j          board read address (cell under test in CHECK)
//   rd_data            combinational board word at (rd_i, rd_j)
//   wr_en, wr_i, wr_j  set revealed bit of (wr_i, wr_j) at next edge
//   busy               high from the cycle after an accepted start until done
//   done               one-cycle completion pulse
//   reveal_cnt         cells revealed by the last cascade
// ---------------------------------------------------------------------------
module revelar_cascada
  import buscaminas_pkg::*;
#(
  parameter int N      = buscaminas_pkg::N,
  parameter int IDX_W  = buscaminas_pkg::IDX_W,
  parameter int QDEPTH = buscaminas_pkg::QDEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [IDX_W-1:0]  i_inicio,
  input  logic [IDX_W-1:0]  j_inicio,
  output logic [IDX_W-1:0]  rd_i,
  output logic [IDX_W-1:0]  rd_j,
  input  logic [CELL_W-1:0] rd_data,
  output logic              wr_en,
  output logic [IDX_W-1:0]  wr_i,
  output logic [IDX_W-1:0]  wr_j,
  output logic              busy,
  output logic              done,
  output logic [6:0]        reveal_cnt
);

`ifdef FLOOD_DIAG_EN
  localparam logic [2:0] K_LAST = 3'd7;
`else
  localparam logic [2:0] K_LAST = 3'd3;
`endif

  state_t            state_q, state_d;
  logic [2:0]        k_q, k_d;
  logic [N*N-1:0]    visited_q, visited_d;
  logic [6:0]        reveal_cnt_q, reveal_cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              push, pop, q_empty, wr_req;
  coord_t            push_data, head, start_coord, nbr;
  logic signed [IDX_W:0] ni, nj;
  logic              nbr_in_range;
  logic              cell_blocked, cell_zero;

  cola_coord #(
    .DEPTH (QDEPTH)
  ) u_cola (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .empty     (q_empty),
    .head      (head)
  );

  assign start_coord = '{i: i_inicio, j: j_inicio};

  // The head register is the cell under inspection for both CHECK and
  // EXPAND, so it drives the read and write addresses directly.
  assign rd_i = head.i;
  assign rd_j = head.j;
  assign wr_i = head.i;
  assign wr_j = head.j;

  assign cell_blocked = rd_data[FLAG_BIT] | rd_data[BOMB_BIT] | rd_data[REVEAL_BIT];
  assign cell_zero    = (rd_data[CNT_MSB:CNT_LSB] == '0);

  // Neighbour k of the head cell. N is 2**IDX_W, so stepping past N-1 or
  // below 0 always lands in the sign bit: the range check is exact.
  assign ni           = $signed({1'b0, head.i}) + off_di(k_q);
  assign nj           = $signed({1'b0, head.j}) + off_dj(k_q);
  assign nbr_in_range = ~ni[IDX_W] & ~nj[IDX_W];
  assign nbr          = '{i: ni[IDX_W-1:0], j: nj[IDX_W-1:0]};

  // A reset sampled in the same cycle must not let a write land.
  assign wr_en = wr_req & ~rst;

  assign busy       = busy_q;
  assign done       = done_q;
  assign reveal_cnt = reveal_cnt_q;

  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    visited_d    = visited_q;
    reveal_cnt_d = reveal_cnt_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    push         = 1'b0;
    push_data    = nbr;
    pop          = 1'b0;
    wr_req       = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          push         = 1'b1;
          push_data    = start_coord;
          visited_d    = '0;
          visited_d[cell_idx(start_coord)] = 1'b1;
          reveal_cnt_d = '0;
          busy_d       = 1'b1;
          state_d      = POP;
        end
      end

      POP: begin
        if (q_empty) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          pop     = 1'b1;
          state_d = CHECK;
        end
      end

      CHECK: begin
        if (cell_blocked) begin
          state_d = POP;
        end else begin
          wr_req       = 1'b1;
          reveal_cnt_d = reveal_cnt_q + 7'd1;
          if (cell_zero) begin
            k_d     = '0;
            state_d = EXPAND;
          end else begin
            state_d = POP;
          end
        end
      end

      EXPAND: begin
        // Marking at push time keeps every cell in the queue at most once,
        // which bounds the queue at N*N entries.
        if (nbr_in_range && !visited_q[cell_idx(nbr)]) begin
          push = 1'b1;
          visited_d[cell_idx(nbr)] = 1'b1;
        end
        if (k_q == K_LAST) begin
          state_d = POP;
        end else begin
          k_d = k_q + 3'd1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      k_q          <= '0;
      visited_q    <= '0;
      reveal_cnt_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      visited_q    <= visited_d;
      reveal_cnt_q <= reveal_cnt_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

endmodule

// File: tb/tb_revelar_cascada.sv
// ---------------------------------------------------------------------------
// tb_revelar_cascada
//   Directed bench for the flood-fill reveal controller. The board register
//   is modelled here: combinational read, revealed bit set shortly after the
//   clock edge that follows a sampled wr_en.
// ---------------------------------------------------------------------------
module tb_revelar_cascada;
  import buscaminas_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [2:0] i_inicio, j_inicio;
  logic [2:0] rd_i, rd_j;
  logic [6:0] rd_data;
  logic       wr_en;
  logic [2:0] wr_i, wr_j;
  logic       busy, done;
  logic [6:0] reveal_cnt;

  logic [6:0] board [8][8];
  int         hits  [8][8];
  int         wr_total;
  int         done_total;
  logic       wr_pend = 1'b0;
  logic [2:0] wr_pi, wr_pj;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef FLOOD_DIAG_EN
  localparam int LAT_FLOOD  = 608;
  localparam int LAT_FLAG   = 178;
  localparam int LAT_CORNER = 18;
  localparam int CNT_CORNER = 4;
  localparam int HIT_16     = 1;
  localparam int WR_AT_RST  = 1;
`else
  localparam int LAT_FLOOD  = 368;
  localparam int LAT_FLAG   = 114;
  localparam int LAT_CORNER = 12;
  localparam int CNT_CORNER = 3;
  localparam int HIT_16     = 0;
  localparam int WR_AT_RST  = 2;
`endif

  always #5 clk = ~clk;

  revelar_cascada dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .i_inicio   (i_inicio),
    .j_inicio   (j_inicio),
    .rd_i       (rd_i),
    .rd_j       (rd_j),
    .rd_data    (rd_data),
    .wr_en      (wr_en),
    .wr_i       (wr_i),
    .wr_j       (wr_j),
    .busy       (busy),
    .done       (done),
    .reveal_cnt (reveal_cnt)
  );

  assign rd_data = board[rd_i][rd_j];

  // Mid-cycle observation of writes and done pulses.
  always @(negedge clk) begin
    wr_pend = (wr_en === 1'b1);
    wr_pi   = wr_i;
    wr_pj   = wr_j;
    if (wr_en === 1'b1) begin
      wr_total++;
      hits[wr_i][wr_j]++;
      $display("write (%0d,%0d)", wr_i, wr_j);
    end
    if (done === 1'b1) done_total++;
  end

  // Board register update, after the DUT has sampled the old word.
  always begin
    @(posedge clk);
    #2;
    if (wr_pend) board[wr_pi][wr_pj][REVEAL_BIT] = 1'b1;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic clear_board();
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        board[i][j] = '0;
  endtask

  task automatic clear_log();
    wr_total   = 0;
    done_total = 0;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        hits[i][j] = 0;
  endtask

  // Called just after a rising edge; returns one cycle after the start edge.
  task automatic pulse_start(input logic [2:0] i, input logic [2:0] j);
    start = 1'b1; i_inicio = i; j_inicio = j;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Cycle n of the loop is n cycles after the start edge's cycle.
  task automatic wait_done(input int budget, output int lat,
                           output logic busy_first, output logic busy_at_done);
    lat = -1; busy_first = 1'bx; busy_at_done = 1'bx;
    for (int n = 1; n <= budget; n++) begin
      @(negedge clk);
      if (n == 1) busy_first = busy;
      if (done === 1'b1) begin
        lat = n; busy_at_done = busy;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  function automatic int revealed_count(input int col_lo);
    int c = 0;
    for (int i = 0; i < 8; i++)
      for (int j = col_lo; j < 8; j++)
        if (board[i][j][REVEAL_BIT]) c++;
    return c;
  endfunction

  function automatic int dup_count();
    int c = 0;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        if (hits[i][j] > 1) c++;
    return c;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b expected 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rst_done: got %b expected 0", done); end
    n_cmp++; if (wr_en !== 1'b0) begin n_bad++; $display("FAIL rst_wr_en: got %b expected 0", wr_en); end
    n_cmp++; if (reveal_cnt !== 7'd0) begin n_bad++; $display("FAIL rst_cnt: got %0d expected 0", reveal_cnt); end
    n_cmp++; if ({rd_i, rd_j} !== 6'd0) begin n_bad++; $display("FAIL rst_rd_addr: got %0d,%0d expected 0,0", rd_i, rd_j); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    $display("reset: checked");
  endtask

  task automatic test_single_nonzero();
    int lat; logic b1, bd;
    clear_board(); board[3][3] = 7'd2; clear_log();
    pulse_start(3'd3, 3'd3);
    wait_done(20, lat, b1, bd);
    n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL single_latency: got %0d expected 4", lat); end
    n_cmp++; if (b1 !== 1'b1) begin n_bad++; $display("FAIL single_busy: got %b expected 1", b1); end
    n_cmp++; if (bd !== 1'b0) begin n_bad++; $display("FAIL single_busy_at_done: got %b expected 0", bd); end
    n_cmp++; if (wr_total !== 1) begin n_bad++; $display("FAIL single_writes: got %0d expected 1", wr_total); end
    n_cmp++; if (hits[3][3] !== 1) begin n_bad++; $display("FAIL single_write_33: got %0d expected 1", hits[3][3]); end
    n_cmp++; if (reveal_cnt !== 7'd1) begin n_bad++; $display("FAIL single_cnt: got %0d expected 1", reveal_cnt); end
    $display("single (3,3): lat=%0d writes=%0d cnt=%0d", lat, wr_total, reveal_cnt);
  endtask

  task automatic test_flood_one_bomb();
    int lat; logic b1, bd;
    clear_board();
    board[6][6] = 7'd1; board[6][7] = 7'd1; board[7][6] = 7'd1;
    board[7][7] = 7'b0010000;
    clear_log();
    pulse_start(3'd0, 3'd0);
    wait_done(1000, lat, b1, bd);
    n_cmp++; if (lat !== LAT_FLOOD) begin n_bad++; $display("FAIL flood_latency: got %0d expected %0d", lat, LAT_FLOOD); end
    n_cmp++; if (reveal_cnt !== 7'd63) begin n_bad++; $display("FAIL flood_cnt: got %0d expected 63", reveal_cnt); end
    n_cmp++; if (wr_total !== 63) begin n_bad++; $display("FAIL flood_writes: got %0d expected 63", wr_total); end
    n_cmp++; if (hits[7][7] !== 0) begin n_bad++; $display("FAIL flood_bomb_written: got %0d expected 0", hits[7][7]); end
    n_cmp++; if (dup_count() !== 0) begin n_bad++; $display("FAIL flood_dup_cells: got %0d expected 0", dup_count()); end
    n_cmp++; if (revealed_count(0) !== 63) begin n_bad++; $display("FAIL flood_board: got %0d expected 63", revealed_count(0)); end
    $display("flood (0,0): lat=%0d writes=%0d cnt=%0d", lat, wr_total, reveal_cnt);
  endtask

  task automatic test_flag_wall();
    int lat; logic b1, bd;
    clear_board();
    for (int r = 0; r < 8; r++) board[r][2] = 7'd1;
    board[2][2] = 7'b1000000;
    clear_log();
    pulse_start(3'd0, 3'd0);
    wait_done(400, lat, b1, bd);
    n_cmp++; if (lat !== LAT_FLAG) begin n_bad++; $display("FAIL flag_latency: got %0d expected %0d", lat, LAT_FLAG); end
    n_cmp++; if (hits[2][2] !== 0) begin n_bad++; $display("FAIL flag_written: got %0d expected 0", hits[2][2]); end
    n_cmp++; if (board[2][2] !== 7'b1000000) begin n_bad++; $display("FAIL flag_cell_word: got %b expected 1000000", board[2][2]); end
    n_cmp++; if (revealed_count(3) !== 0) begin n_bad++; $display("FAIL flag_beyond_revealed: got %0d expected 0", revealed_count(3)); end
    n_cmp++; if (reveal_cnt !== 7'd23) begin n_bad++; $display("FAIL flag_cnt: got %0d expected 23", reveal_cnt); end
    n_cmp++; if (wr_total !== 23) begin n_bad++; $display("FAIL flag_writes: got %0d expected 23", wr_total); end
    $display("flag wall (0,0): lat=%0d writes=%0d cnt=%0d", lat, wr_total, reveal_cnt);
  endtask

  task automatic test_corner();
    int lat; logic b1, bd;
    clear_board();
    board[0][6] = 7'd1; board[1][6] = 7'd1; board[1][7] = 7'd1;
    clear_log();
    pulse_start(3'd0, 3'd7);
    wait_done(100, lat, b1, bd);
    n_cmp++; if (lat !== LAT_CORNER) begin n_bad++; $display("FAIL corner_latency: got %0d expected %0d", lat, LAT_CORNER); end
    n_cmp++; if (reveal_cnt !== 7'(CNT_CORNER)) begin n_bad++; $display("FAIL corner_cnt: got %0d expected %0d", reveal_cnt, CNT_CORNER); end
    n_cmp++; if (hits[0][0] !== 0) begin n_bad++; $display("FAIL corner_wrap_east: got %0d expected 0", hits[0][0]); end
    n_cmp++; if (hits[7][7] !== 0) begin n_bad++; $display("FAIL corner_wrap_north: got %0d expected 0", hits[7][7]); end
    n_cmp++; if (hits[1][6] !== HIT_16) begin n_bad++; $display("FAIL corner_sw_cell: got %0d expected %0d", hits[1][6], HIT_16); end
    $display("corner (0,7): lat=%0d writes=%0d cnt=%0d", lat, wr_total, reveal_cnt);
  endtask

  task automatic test_revealed_and_busy_start();
    int lat; logic b1, bd;
    clear_board(); board[4][4] = 7'b0100000; clear_log();
    pulse_start(3'd4, 3'd4);
    @(posedge clk); #1;
    start = 1'b1; i_inicio = 3'd0; j_inicio = 3'd0;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(20, lat, b1, bd);
    repeat (10) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL revealed_latency: got %0d expected 2 after second start", lat); end
    n_cmp++; if (done_total !== 1) begin n_bad++; $display("FAIL revealed_done_pulses: got %0d expected 1", done_total); end
    n_cmp++; if (wr_total !== 0) begin n_bad++; $display("FAIL revealed_writes: got %0d expected 0", wr_total); end
    n_cmp++; if (reveal_cnt !== 7'd0) begin n_bad++; $display("FAIL revealed_cnt: got %0d expected 0", reveal_cnt); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL revealed_busy_after: got %b expected 0", busy); end
    @(posedge clk); #1;
    $display("revealed start (4,4) + busy start: done=%0d writes=%0d", done_total, wr_total);
  endtask

  task automatic test_reset_mid();
    int lat; logic b1, bd;
    clear_board(); clear_log();
    pulse_start(3'd0, 3'd0);
    repeat (9) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (wr_en !== 1'b0) begin n_bad++; $display("FAIL midrst_wr_in_rst: got %b expected 0", wr_en); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    n_cmp++; if (wr_en !== 1'b0) begin n_bad++; $display("FAIL midrst_wr_en: got %b expected 0", wr_en); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL midrst_done: got %b expected 0", done); end
    n_cmp++; if (reveal_cnt !== 7'd0) begin n_bad++; $display("FAIL midrst_cnt: got %0d expected 0", reveal_cnt); end
    n_cmp++; if (wr_total !== WR_AT_RST) begin n_bad++; $display("FAIL midrst_writes_before: got %0d expected %0d", wr_total, WR_AT_RST); end
    repeat (6) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (done_total !== 0) begin n_bad++; $display("FAIL midrst_stray_done: got %0d expected 0", done_total); end
    @(posedge clk); #1;
    clear_board(); board[3][3] = 7'd2; clear_log();
    pulse_start(3'd3, 3'd3);
    wait_done(20, lat, b1, bd);
    n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL midrst_restart_latency: got %0d expected 4", lat); end
    n_cmp++; if (reveal_cnt !== 7'd1) begin n_bad++; $display("FAIL midrst_restart_cnt: got %0d expected 1", reveal_cnt); end
    n_cmp++; if (wr_total !== 1) begin n_bad++; $display("FAIL midrst_restart_writes: got %0d expected 1", wr_total); end
    $display("reset mid-cascade then restart (3,3): lat=%0d cnt=%0d", lat, reveal_cnt);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; i_inicio = '0; j_inicio = '0;
    clear_board(); clear_log();
    test_reset();
    test_single_nonzero();
    test_flood_one_bomb();
    test_flag_wall();
    test_corner();
    test_revealed_and_busy_start();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
